stand_mode_controller_multi: RTL and testbench

- Parametrised, multi-channel button event controller for the hood front panel.
- Takes N debounced button levels plus the current operating mode.
- Per channel, emits a one-cycle short-press pulse on release, or a one-cycle long-press pulse once the button has been held LONG_CYCLES.
- Events are gated by a per-channel mode-enable mask. It sits between the debouncers and the mode FSM and replaces the single-button, OFF-only toggle generator.

---
 rtl/stand_mode_controller_multi.sv | 150 +++++++++++++++
 tb/tb_stand_mode_controller_multi.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stand_mode_controller_multi.sv
// ----------------------------------------------------------------------------
// stand_mode_controller_multi
//
// Multi-channel button event generator for the hood front panel. It sits
// between the per-button debouncers and the mode FSM. Each channel turns a
// debounced button level into one of two single-cycle events:
//   - short press : emitted on release, if the button was released before the
//                   long-press threshold was reached
//   - long press  : emitted once the button has been held LONG_CYCLES cycles;
//                   the following release is then silent
// A per-channel, per-mode enable mask decides whether a press is honoured.
// If the mode changes to a disabled one while a press is tracked, the press
// is abandoned without an event.
//
// Parameters
//   N_BTN       number of independent button channels
//   MODE_WIDTH  width of current_mode (global mode encoding)
//   LONG_CYCLES hold time in clk cycles for a long press (>= 2)
//   MODE_MASK   bit [i*2^MODE_WIDTH + m] enables channel i in mode m
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   btn_level     debounced button levels, 1 = pressed, synchronous to clk
//   current_mode  current hood mode
//   short_pulse   one-cycle short-press event per channel (registered)
//   long_pulse    one-cycle long-press event per channel (registered)
//   busy          channel is tracking a valid press
// ----------------------------------------------------------------------------
module stand_mode_controller_multi #(
    parameter int N_BTN       = 4,
    parameter int MODE_WIDTH  = 3,
    parameter int LONG_CYCLES = 300000000,
    parameter logic [N_BTN*(2**MODE_WIDTH)-1:0] MODE_MASK = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BTN-1:0]      btn_level,
    input  logic [MODE_WIDTH-1:0] current_mode,
    output logic [N_BTN-1:0]      short_pulse,
    output logic [N_BTN-1:0]      long_pulse,
    output logic [N_BTN-1:0]      busy
);

    localparam int N_MODES = 2**MODE_WIDTH;
    localparam int CNT_W   = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_HELD       = 2'd1;
    localparam logic [1:0] ST_LONG_FIRED = 2'd2;
    localparam logic [1:0] ST_BLOCKED    = 2'd3;

    logic [N_BTN-1:0] r_prev;
    logic [N_BTN-1:0] r_short;
    logic [N_BTN-1:0] r_long;
    logic [1:0]       r_state [N_BTN];
    logic [CNT_W-1:0] r_cnt   [N_BTN];

    logic [N_BTN-1:0]   w_rise;
    logic [N_BTN-1:0]   w_fall;
    logic [N_BTN-1:0]   w_allowed;
    logic [N_MODES-1:0] w_ch_mask [N_BTN];

    assign w_rise = btn_level & ~r_prev;
    assign w_fall = ~btn_level & r_prev;

    // Slice out each channel's mode-enable row so the live mode indexes a
    // vector of exactly 2^MODE_WIDTH bits.
    for (genvar g = 0; g < N_BTN; g++) begin : g_mask
        assign w_ch_mask[g] = MODE_MASK[g*N_MODES +: N_MODES];
        assign w_allowed[g] = w_ch_mask[g][current_mode];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // prev resets to all ones so a button held through reset is
            // never seen as a new press.
            r_prev  <= '1;
            r_short <= '0;
            r_long  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_prev  <= btn_level;
            r_short <= '0;
            r_long  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_rise[i]) begin
                            if (w_allowed[i]) begin
                                r_state[i] <= ST_HELD;
                                r_cnt[i]   <= CNT_ONE;
                            end else begin
                                r_state[i] <= ST_BLOCKED;
                            end
                        end
                    end
                    ST_HELD: begin
                        if (!w_allowed[i]) begin
                            // Mode left the enabled set: abandon silently and
                            // wait for release if the button is still down.
                            r_state[i] <= w_fall[i] ? ST_IDLE : ST_BLOCKED;
                            r_cnt[i]   <= '0;
                        end else if (w_fall[i]) begin
                            // Release wins over the threshold, so a hold of
                            // LONG_CYCLES-1 cycles is still a short press.
                            r_state[i] <= ST_IDLE;
                            r_short[i] <= 1'b1;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            // Leaving HELD here is what keeps the counter
                            // from ever wrapping.
                            r_state[i] <= ST_LONG_FIRED;
                            r_long[i]  <= 1'b1;
                            r_cnt[i]   <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                    ST_LONG_FIRED, ST_BLOCKED: begin
                        if (w_fall[i]) begin
                            r_state[i] <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < N_BTN; i++) begin
            busy[i] = (r_state[i] == ST_HELD);
        end
    end

    assign short_pulse = r_short;
    assign long_pulse  = r_long;

endmodule

// File: tb/tb_stand_mode_controller_multi.sv
module tb_stand_mode_controller_multi;

    localparam int N_BTN      = 4;
    localparam int MODE_WIDTH = 3;
    localparam int LC         = 10;
    // ch0 enabled in mode 0 only, every other channel enabled in all modes.
    localparam logic [31:0] MASK = {24'hFF_FFFF, 8'h01};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [2:0] mode = 3'd0;
    logic [3:0] sp;
    logic [3:0] lp;
    logic [3:0] bz;

    stand_mode_controller_multi #(
        .N_BTN       (N_BTN),
        .MODE_WIDTH  (MODE_WIDTH),
        .LONG_CYCLES (LC),
        .MODE_MASK   (MASK)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .btn_level    (btn),
        .current_mode (mode),
        .short_pulse  (sp),
        .long_pulse   (lp),
        .busy         (bz)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [11:0] exp_q[$];

    // reference model state: 0 idle, 1 tracking, 2 long done, 3 ignored
    logic [3:0] m_prev;
    int         m_st  [4];
    int         m_len [4];

    // observation counters
    int cs [4];
    int cl [4];
    int cyc = 0;
    int busy0 = 0;
    int long0_cyc = -1;
    int both12 = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic reset_model();
        m_prev = 4'b1111;
        for (int ch = 0; ch < 4; ch++) begin
            m_st[ch]  = 0;
            m_len[ch] = 0;
        end
    endtask

    task automatic model(input logic [3:0] b, input logic [2:0] m, output logic [11:0] e);
        logic [3:0]  es;
        logic [3:0]  el;
        logic [3:0]  eb;
        logic [31:0] sh;
        logic        en;
        logic        up;
        logic        dn;
        es = '0;
        el = '0;
        eb = '0;
        if (rst) begin
            reset_model();
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                sh = MASK >> (ch * 8 + int'(m));
                en = sh[0];
                up = b[ch] & ~m_prev[ch];
                dn = ~b[ch] & m_prev[ch];
                if (m_st[ch] == 0) begin
                    if (up) begin
                        m_st[ch]  = en ? 1 : 3;
                        m_len[ch] = 1;
                    end
                end else if (m_st[ch] == 1) begin
                    if (!en) begin
                        m_st[ch] = dn ? 0 : 3;
                    end else if (dn) begin
                        es[ch]   = 1'b1;
                        m_st[ch] = 0;
                    end else if (m_len[ch] == LC - 1) begin
                        el[ch]   = 1'b1;
                        m_st[ch] = 2;
                    end else begin
                        m_len[ch]++;
                    end
                end else if (dn) begin
                    m_st[ch] = 0;
                end
                eb[ch] = (m_st[ch] == 1);
            end
            m_prev = b;
        end
        e = {es, el, eb};
    endtask

    task automatic step(input logic [3:0] b, input logic [2:0] m);
        logic [11:0] e;
        logic [11:0] q;
        btn  = b;
        mode = m;
        model(b, m, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        q = exp_q.pop_front();
        chk("short_pulse", int'(sp), int'(q[11:8]));
        chk("long_pulse",  int'(lp), int'(q[7:4]));
        chk("busy",        int'(bz), int'(q[3:0]));
        for (int ch = 0; ch < 4; ch++) begin
            cs[ch] += int'(sp[ch]);
            cl[ch] += int'(lp[ch]);
        end
        if (lp[0]) long0_cyc = cyc;
        if (sp == 4'b0110) both12++;
        if (bz[0]) busy0++;
    endtask

    task automatic hold(input logic [3:0] b, input logic [2:0] m, input int n);
        for (int k = 0; k < n; k++) step(b, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, l0, s1, l1, s2, s3, l3, d0, b0;
        logic [3:0] rb;
        logic [2:0] rm;
        for (int ch = 0; ch < 4; ch++) begin
            cs[ch] = 0;
            cl[ch] = 0;
        end
        reset_model();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_short", int'(sp), 0);
        chk("reset_long",  int'(lp), 0);
        chk("reset_busy",  int'(bz), 0);
        rst = 1'b0;
        hold(4'b0000, 3'd0, 2);

        // short press on ch0 in mode 0
        s0 = cs[0]; l0 = cl[0]; b0 = busy0;
        hold(4'b0001, 3'd0, 4);
        hold(4'b0000, 3'd0, 3);
        chk("short_cnt", cs[0] - s0, 1);
        chk("short_nolong", cl[0] - l0, 0);
        chk("short_busy_len", busy0 - b0, 4);

        // long press on ch0, latency counted from the cycle it is driven high
        s0 = cs[0]; l0 = cl[0]; d0 = cyc;
        hold(4'b0001, 3'd0, 25);
        hold(4'b0000, 3'd0, 3);
        chk("long_cnt", cl[0] - l0, 1);
        chk("long_noshort", cs[0] - s0, 0);
        chk("long_latency", long0_cyc - d0, LC);

        // boundary: LC-1 cycles of hold is still a short press
        s0 = cs[0]; l0 = cl[0];
        hold(4'b0001, 3'd0, LC - 1);
        hold(4'b0000, 3'd0, 3);
        chk("edge_short", cs[0] - s0, 1);
        chk("edge_nolong", cl[0] - l0, 0);

        // mode gating: ch0 in mode 2, then mode switch mid-press
        s0 = cs[0]; l0 = cl[0]; b0 = busy0;
        hold(4'b0001, 3'd2, 4);
        hold(4'b0000, 3'd2, 2);
        chk("gate_busy", busy0 - b0, 0);
        hold(4'b0001, 3'd0, 3);
        hold(4'b0001, 3'd1, 3);
        hold(4'b0000, 3'd1, 3);
        chk("gate_short", cs[0] - s0, 0);
        chk("gate_long", cl[0] - l0, 0);

        // simultaneous channels
        s1 = cs[1]; s2 = cs[2]; s3 = cs[3]; l3 = cl[3]; l1 = cl[1];
        hold(4'b1110, 3'd5, 3);
        hold(4'b1000, 3'd5, 12);
        hold(4'b0000, 3'd5, 3);
        chk("sim_same_cycle", both12, 1);
        chk("sim_ch1", cs[1] - s1, 1);
        chk("sim_ch2", cs[2] - s2, 1);
        chk("sim_ch3_long", cl[3] - l3, 1);
        chk("sim_ch3_noshort", cs[3] - s3, 0);
        chk("sim_ch1_nolong", cl[1] - l1, 0);

        // single-cycle press on ch2
        s2 = cs[2];
        hold(4'b0100, 3'd3, 1);
        hold(4'b0000, 3'd3, 2);
        chk("pulse1_short", cs[2] - s2, 1);

        // reset in the middle of a ch1 hold, ch1 kept high across reset
        s1 = cs[1]; l1 = cl[1];
        hold(4'b0010, 3'd0, 5);
        rst = 1'b1;
        #1;
        chk("midrst_short", int'(sp), 0);
        chk("midrst_long",  int'(lp), 0);
        chk("midrst_busy",  int'(bz), 0);
        reset_model();
        hold(4'b0010, 3'd0, 2);
        rst = 1'b0;
        hold(4'b0010, 3'd0, 12);
        hold(4'b0000, 3'd0, 3);
        chk("rst_no_short", cs[1] - s1, 0);
        chk("rst_no_long", cl[1] - l1, 0);
        hold(4'b0010, 3'd0, 4);
        hold(4'b0000, 3'd0, 2);
        chk("rst_next_press", cs[1] - s1, 1);

        // random traffic, checked against the model only
        rb = 4'b0000;
        rm = 3'd0;
        for (int k = 0; k < 400; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 5) == 0) rb[ch] = ~rb[ch];
            end
            if ($urandom_range(0, 15) == 0) rm = 3'($urandom_range(0, 7));
            step(rb, rm);
        end
        hold(4'b0000, 3'd0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
